div_ctrl: RTL and testbench

//  Iterative radix-2 divider sequencer for the EX stage: runs DIV/DIVU over

---
 rtl/div_ctrl_pkg.sv | 20 ++
 rtl/div_ctrl_step.sv | 33 +++
 rtl/div_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_div_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the EX-stage divider sequencer: FSM state encodings
// and the ready/start control constants used by the divider and its driver.
// ----------------------------------------------------------------------------
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_ctrl_step.sv
// ----------------------------------------------------------------------------
// div_ctrl_step
// One combinational restoring-division iteration: trial-subtract the divisor
// from the upper window of the shifting dividend register and either keep the
// difference (shifting in a quotient 1) or just shift (quotient 0).
// Ports:
//   dividend      in   2*WIDTH    dividend register bits [2W-1:0]
//                                 (the top bit is shifted out either way)
//   divisor       in   WIDTH      divisor magnitude
//   dividend_next out  2*WIDTH+1  dividend register after this iteration
// ----------------------------------------------------------------------------
module div_ctrl_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH:0]   dividend_next
);

    logic [WIDTH:0] diff;

    // WIDTH+1-bit subtract so the top bit is a clean borrow flag.
    assign diff = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

    always_comb begin
        if (diff[WIDTH]) begin
            dividend_next = {dividend, 1'b0};
        end else begin
            dividend_next = {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// ----------------------------------------------------------------------------
// div_ctrl
// Iterative radix-2 DIV/DIVU sequencer for the EX stage. Runs WIDTH iterations
// plus load and finalize cycles, holds the pipeline via stallreq_o while busy
// and presents {remainder, quotient} for the HI/LO write path.
// Ports:
//   clk         in   1        clock
//   rst         in   1        synchronous reset, active-high
//   start_i     in   1        EX holds a divide (held until ready_o seen)
//   annul_i     in   1        cancel the in-flight divide
//   signed_i    in   1        1 = DIV (two's complement), 0 = DIVU
//   op1_i       in   WIDTH    dividend
//   op2_i       in   WIDTH    divisor
//   result_o    out  2*WIDTH  {remainder, quotient}
//   ready_o     out  1        result_o valid (registered)
//   stallreq_o  out  1        combinational stall request
// ----------------------------------------------------------------------------
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   op1_i,
    input  logic [WIDTH-1:0]   op2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    // Two's complement negation modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Magnitude of an operand; only signed operands with MSB set are negated.
    function automatic logic [WIDTH-1:0] magnitude(input logic sgn,
                                                   input logic [WIDTH-1:0] x);
        return (sgn && x[WIDTH-1]) ? twos_neg(x) : x;
    endfunction

    div_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2*WIDTH:0]   dividend, dividend_n;
    logic [WIDTH-1:0]   divisor, divisor_n;
    logic               sgn_div, sgn_div_n;
    logic               neg_op1, neg_op1_n;
    logic               neg_op2, neg_op2_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;

    logic [2*WIDTH:0]   dividend_step;
    logic [WIDTH-1:0]   quot_fin;
    logic [WIDTH-1:0]   rem_fin;

    div_ctrl_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .dividend      (dividend[2*WIDTH-1:0]),
        .divisor       (divisor),
        .dividend_next (dividend_step)
    );

    // Sign correction uses the operand signs captured at load time, because
    // op1_i/op2_i are free to change while the iterations run.
    always_comb begin
        quot_fin = dividend[WIDTH-1:0];
        rem_fin  = dividend[2*WIDTH:WIDTH+1];
        if (sgn_div && (neg_op1 ^ neg_op2)) begin
            quot_fin = twos_neg(dividend[WIDTH-1:0]);
        end
        if (sgn_div && neg_op1) begin
            rem_fin = twos_neg(dividend[2*WIDTH:WIDTH+1]);
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dividend_n = dividend;
        divisor_n  = divisor;
        sgn_div_n  = sgn_div;
        neg_op1_n  = neg_op1;
        neg_op2_n  = neg_op2;
        result_n   = result_o;
        ready_n    = ready_o;
        stallreq_o = 1'b0;

        case (state)
            DIV_FREE: begin
                ready_n  = DIV_RESULT_NOT_READY;
                result_n = '0;
                if (start_i == DIV_START && !annul_i) begin
                    stallreq_o = 1'b1;
                    if (op2_i == '0) begin
                        state_n = DIV_BYZERO;
                    end else begin
                        state_n    = DIV_ON;
                        cnt_n      = '0;
                        dividend_n = {{WIDTH{1'b0}}, magnitude(signed_i, op1_i), 1'b0};
                        divisor_n  = magnitude(signed_i, op2_i);
                        sgn_div_n  = signed_i;
                        neg_op1_n  = op1_i[WIDTH-1];
                        neg_op2_n  = op2_i[WIDTH-1];
                    end
                end
            end

            DIV_BYZERO: begin
                stallreq_o = 1'b1;
                result_n   = '0;
                if (annul_i) begin
                    state_n = DIV_FREE;
                    ready_n = DIV_RESULT_NOT_READY;
                end else begin
                    state_n = DIV_END;
                    ready_n = DIV_RESULT_READY;
                end
            end

            DIV_ON: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    state_n  = DIV_FREE;
                    ready_n  = DIV_RESULT_NOT_READY;
                    result_n = '0;
                end else if (cnt != CNT_LAST) begin
                    dividend_n = dividend_step;
                    cnt_n      = cnt + CNT_W'(1);
                end else begin
                    state_n  = DIV_END;
                    result_n = {rem_fin, quot_fin};
                    ready_n  = DIV_RESULT_READY;
                end
            end

            DIV_END: begin
                // Result is held until EX drops start_i (i.e. it has advanced).
                if (annul_i || start_i == DIV_STOP) begin
                    state_n  = DIV_FREE;
                    ready_n  = DIV_RESULT_NOT_READY;
                    result_n = '0;
                end
            end

            default: begin
                state_n  = DIV_FREE;
                ready_n  = DIV_RESULT_NOT_READY;
                result_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            sgn_div  <= 1'b0;
            neg_op1  <= 1'b0;
            neg_op2  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dividend <= dividend_n;
            divisor  <= divisor_n;
            sgn_div  <= sgn_div_n;
            neg_op1  <= neg_op1_n;
            neg_op2  <= neg_op2_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_div_ctrl
// Scoreboard bench for div_ctrl: each issued divide pushes its expected
// {rem, quot} and latency; a monitor pops and compares on every ready_o rise.
// ----------------------------------------------------------------------------
module tb_div_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          annul;
    logic          sgn;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic [2*W-1:0] result;
    logic          ready;
    logic          stallreq;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [2*W-1:0] res;
        int unsigned    t0;
        int unsigned    lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic ready_q = 1'b0;

    div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .annul_i    (annul),
        .signed_i   (sgn),
        .op1_i      (op1),
        .op2_i      (op2),
        .result_o   (result),
        .ready_o    (ready),
        .stallreq_o (stallreq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: division by magnitudes, then MIPS sign rules
    // (quotient sign = sign xor, remainder takes dividend's sign), mod 2^32.
    function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint ma, mb, q, r;
        logic [W-1:0] qq, rr;
        if (b == 0) return '0;
        if (!s) return {a % b, a / b};
        ma = longint'($signed(a));
        mb = longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        q = ma / mb;
        r = ma % mb;
        if (($signed(a) < 0) != ($signed(b) < 0)) q = -q;
        if ($signed(a) < 0) r = -r;
        qq = q[W-1:0];
        rr = r[W-1:0];
        return {rr, qq};
    endfunction

    // Monitor: every rising ready_o must match the oldest outstanding divide.
    always @(negedge clk) begin
        if (ready && !ready_q) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=%h expected=no_result", result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            end
        end
        ready_q <= ready;
    end

    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold);
        exp_t e;
        logic [2*W-1:0] er;
        bit got;
        er = ref_div(s, a, b);
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn   = s;
        op1   = a;
        op2   = b;
        e.res = er;
        e.t0  = cyc;
        e.lat = (b == 0) ? 2 : 34;
        sb.push_back(e);
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
            end else begin
                chk("stall_busy", 64'(stallreq), 64'(1));
                if (n > 0) begin
                    op1 = $urandom;
                    op2 = $urandom;
                end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=no_ready expected=ready_within_40");
            if (sb.size() > 0) void'(sb.pop_back());
            start = 1'b0;
            @(negedge clk);
        end else begin
            chk("stall_end", 64'(stallreq), 64'(0));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_result", result, er);
                chk("hold_ready", 64'(ready), 64'(1));
            end
            start = 1'b0;
            @(negedge clk);
            chk("drop_ready", 64'(ready), 64'(0));
            chk("drop_result", result, 64'(0));
        end
    endtask

    // Start a divide, then abort it after 'edges' edges with annul or reset.
    task automatic abort_div(input bit use_rst, input int edges);
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn   = 1'b0;
        op1   = $urandom;
        op2   = $urandom_range(1, 1000);
        repeat (edges) @(posedge clk);
        #1;
        start = 1'b0;
        if (use_rst) rst = 1'b1;
        else         annul = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        chk(use_rst ? "rst_ready" : "annul_ready", 64'(ready), 64'(0));
        chk(use_rst ? "rst_result" : "annul_result", result, 64'(0));
        chk(use_rst ? "rst_stall" : "annul_stall", 64'(stallreq), 64'(0));
        repeat (40) @(negedge clk);
        chk(use_rst ? "rst_quiet" : "annul_quiet", 64'(ready), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        sgn   = 1'b0;
        op1   = '0;
        op2   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'(0));
        chk("reset_result", result, 64'(0));
        chk("reset_stall", 64'(stallreq), 64'(0));

        run_div(1'b0, 32'd100, 32'd7, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(1'b0, 32'd1234, 32'd0, 1);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0);
        run_div(1'b0, 32'd100, 32'd7, 3);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_div(1'b1, 32'd5, 32'hFFFF_FFFE, 0);

        // annul sampled on the edge after cnt reached 10 (edge 12)
        abort_div(1'b0, 11);
        run_div(1'b0, 32'd9, 32'd3, 0);

        // reset sampled on the edge after cnt reached 20 (edge 22)
        abort_div(1'b1, 21);
        run_div(1'b1, 32'hFFFF_FF00, 32'd7, 0);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_div(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
